axi_wdata_sched: RTL and testbench
==================================

// Module: axi_wdata_sched
// PURPOSE
//  Sequences the write-data receive channel (axi_wdata_chs) per write burst.
//  - Queues translation verdicts (ok/fault + awlen) in order.
//  - Issues exactly one done/drop pulse per burst.
//  - Tracks W beats, or waits for drop_done, to detect the end of each burst.
//  - Emits one completion (resp + length check) per burst toward B-channel logic.
//  - Guarantees at most one burst outstanding in the W channel, so its done/drop latches never stack.
// PARAMETERS
//  QDEPTH     8  verdict queue depth (power of 2, >=2)
//  LEN_WIDTH  8  AXI awlen width; burst = awlen+1 beats
// PORTS
//  clk          in   1            single clock, rising edge
//  reset_       in   1            synchronous, active-low reset
//  in_tvalid    in   1            translation verdict valid
//  out_tready   out  1            verdict accepted when in_tvalid & out_tready
//  in_tok       in   1            1 = translation success, 0 = fault
//  in_tlen      in   LEN_WIDTH    awlen of the translated burst
//  out_done     out  1            1-cycle pulse to W channel "done"
//  out_drop     out  1            1-cycle pulse to W channel "drop"
//  in_drop_done in   1            W channel finished discarding a burst
//  mon_wvalid   in   1            downstream W valid (monitor only)
//  mon_wready   in   1            downstream W ready (monitor only)
//  mon_wlast    in   1            downstream W last (monitor only)
//  out_cvalid   out  1            completion valid, held until in_cready
//  in_cready    in   1            completion consumer ready
//  out_cresp    out  2            2'b00 OKAY, 2'b10 SLVERR
//  out_len_err  out  1            completion flag: beat count != awlen+1
//  out_pending  out  clog2(QDEPTH)+1  verdicts queued, excluding the current burst
//  out_busy     out  1            FSM not in IDLE
// BEHAVIOUR
//  Reset (reset_=0 at posedge):
//  - queue flushed; FSM -> IDLE.
//  - All outputs 0, except out_tready=1 after the reset edge.
//  - Applies mid-burst too: no pulse or completion for the aborted burst.
//  Queue:
//  - out_tready = ~full.
//  - Push on in_tvalid & out_tready, storing {in_tok, in_tlen}.
//  - Pop only in IDLE when not empty.
//  - Push and pop in the same cycle are both honoured; out_pending stays unchanged.
//  FSM (registered outputs; state is encoded per the shared package):
//  - IDLE:
//    - If queue not empty: pop, latch cur_ok/cur_len, -> ISSUE.
//    - Otherwise stay.
//  - ISSUE (exactly 1 cycle):
//    - out_done=cur_ok, out_drop=~cur_ok; beat counter cleared.
//    - Next state: SEND if cur_ok, otherwise DROP.
//  - SEND:
//    - A beat is mon_wvalid & mon_wready; each beat increments a LEN_WIDTH+1 bit counter.
//    - Counter saturates at all-ones.
//    - On a beat with mon_wlast: len_err = (count_incl_this_beat != cur_len+1).
//    - Completion resp = len_err ? SLVERR : OKAY; -> RESP.
//    - A beat count passing cur_len+1 without wlast sets len_err; stay in SEND until wlast.
//  - DROP:
//    - mon_* ignored.
//    - On in_drop_done: resp = SLVERR, len_err = 0; -> RESP.
//  - RESP:
//    - out_cvalid=1; out_cresp and out_len_err held stable while out_cvalid.
//    - On in_cready: -> IDLE, out_cvalid=0 at the next edge.
//  Timing:
//  - Latency: verdict pushed at edge N, queue previously empty, IDLE -> pulse visible in cycle N+2.
//  - Back-to-back bursts: at least 1 IDLE cycle between RESP and the next ISSUE.
//  Boundary cases:
//  - in_drop_done or a wlast beat outside DROP/SEND is ignored. The bench asserts this never occurs.
//  - in_drop_done arriving in the same cycle as entry to DROP is accepted.
//  - Queue full: the verdict stays pending upstream (tvalid held); no loss, no overwrite.
//  - Pulses never coincide: out_done & out_drop == 0 always.
// STRUCTURE
//  - Package axi_mm_pkg: RESP_OKAY/RESP_SLVERR, FSM state localparams, verdict struct width (LEN_WIDTH+1).
//  - Sub-module: the existing synch_fifo as the verdict queue (DW=LEN_WIDTH+1, FIFO_DEPTH=QDEPTH).
//  - FSM, beat counter and completion registers are local.
// TESTING
//  1. ok, tlen=3; 4 beats, wlast on 4th
//     -> one out_done pulse; then cvalid with cresp=00, len_err=0; cready -> busy=0.
//  2. fault, tlen=7; in_drop_done 5 cycles after out_drop
//     -> one out_drop pulse; completion cresp=10, len_err=0; no out_done.
//  3. ok, tlen=3; wlast on 2nd beat
//     -> completion cresp=10, len_err=1.
//  4. Push 8 verdicts (ok, fault, ok, ...) with no drain
//     -> out_tready=0 after the 8th push, out_pending=7 after the first pop;
//     -> all 8 pulses issued in push order as bursts complete.
//  5. cready held low 10 cycles in RESP
//     -> cvalid/cresp stable; no new pulse issued until cready.
//  6. reset_=0 mid-SEND with 2 verdicts queued
//     -> next cycle all outputs 0, out_pending=0, no completion for the aborted burst.

Source files
------------

// File: rtl/axi_mm_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_mm_pkg : shared AXI response codes and W-scheduler state encoding |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
package axi_mm_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_SEND  = 3'd2;
  localparam logic [2:0] ST_DROP  = 3'd3;
  localparam logic [2:0] ST_RESP  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_SEND  = ST_SEND,
    S_DROP  = ST_DROP,
    S_RESP  = ST_RESP
  } sched_state_e;

  // Stored verdict is {tok, tlen}.
  function automatic int unsigned verdict_width(input int unsigned len_width);
    return len_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/synch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | synch_fifo : single-clock show-ahead FIFO, power-of-2 depth           |
// | Revision   : 1.0                                                      |
// +----------------------------------------------------------------------+
module synch_fifo #(
  parameter int DW         = 9,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_,
  input  logic                        wr_en,
  input  logic [DW-1:0]               wr_data,
  input  logic                        rd_en,
  output logic [DW-1:0]               rd_data,
  output logic                        full,
  output logic                        empty,
  output logic [$clog2(FIFO_DEPTH):0] count
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_wr, do_rd;

  // Depth is a power of two, so the top count bit alone marks full.
  assign full    = count_q[AW];
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];
  assign do_wr   = wr_en & ~full;
  assign do_rd   = rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/axi_wdata_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | axi_wdata_sched : per-burst done/drop sequencing and completion for   |
// |                   the W receive channel                               |
// | Revision        : 1.0                                                 |
// +----------------------------------------------------------------------+
module axi_wdata_sched
  import axi_mm_pkg::*;
#(
  parameter int QDEPTH    = 8,
  parameter int LEN_WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_,
  input  logic                     in_tvalid,
  output logic                     out_tready,
  input  logic                     in_tok,
  input  logic [LEN_WIDTH-1:0]     in_tlen,
  output logic                     out_done,
  output logic                     out_drop,
  input  logic                     in_drop_done,
  input  logic                     mon_wvalid,
  input  logic                     mon_wready,
  input  logic                     mon_wlast,
  output logic                     out_cvalid,
  input  logic                     in_cready,
  output logic [1:0]               out_cresp,
  output logic                     out_len_err,
  output logic [$clog2(QDEPTH):0]  out_pending,
  output logic                     out_busy
);

  localparam int VW = int'(verdict_width(LEN_WIDTH));
  localparam logic [LEN_WIDTH:0] CNT_ONE = {{LEN_WIDTH{1'b0}}, 1'b1};

  logic                 q_full, q_empty, q_pop;
  logic [VW-1:0]        q_rdata;

  sched_state_e         state_q, state_d;
  logic                 cur_ok_q, cur_ok_d;
  logic [LEN_WIDTH-1:0] cur_len_q, cur_len_d;
  logic [LEN_WIDTH:0]   cnt_q, cnt_d;
  logic                 over_q, over_d;
  logic [1:0]           cresp_q, cresp_d;
  logic                 len_err_q, len_err_d;
  logic                 done_q, done_d;
  logic                 drop_q, drop_d;

  logic                 beat;
  logic [LEN_WIDTH:0]   cnt_inc;
  logic [LEN_WIDTH:0]   burst_len;
  logic                 last_err;

  synch_fifo #(
    .DW         (VW),
    .FIFO_DEPTH (QDEPTH)
  ) u_verdict_q (
    .clk     (clk),
    .reset_  (reset_),
    .wr_en   (in_tvalid),
    .wr_data ({in_tok, in_tlen}),
    .rd_en   (q_pop),
    .rd_data (q_rdata),
    .full    (q_full),
    .empty   (q_empty),
    .count   (out_pending)
  );

  assign out_tready = ~q_full;

  assign beat      = mon_wvalid & mon_wready;
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;
  assign burst_len = {1'b0, cur_len_q} + CNT_ONE;
  assign last_err  = over_q | (cnt_inc != burst_len);

  always_comb begin
    state_d   = state_q;
    cur_ok_d  = cur_ok_q;
    cur_len_d = cur_len_q;
    cnt_d     = cnt_q;
    over_d    = over_q;
    cresp_d   = cresp_q;
    len_err_d = len_err_q;
    done_d    = 1'b0;
    drop_d    = 1'b0;
    q_pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!q_empty) begin
          q_pop     = 1'b1;
          cur_ok_d  = q_rdata[VW-1];
          cur_len_d = q_rdata[LEN_WIDTH-1:0];
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        done_d  = cur_ok_q;
        drop_d  = ~cur_ok_q;
        cnt_d   = '0;
        over_d  = 1'b0;
        state_d = cur_ok_q ? S_SEND : S_DROP;
      end
      S_SEND: begin
        if (beat) begin
          cnt_d = cnt_inc;
          if (mon_wlast) begin
            len_err_d = last_err;
            cresp_d   = last_err ? RESP_SLVERR : RESP_OKAY;
            state_d   = S_RESP;
          end else if (cnt_inc > burst_len) begin
            // Overrun is remembered until the late wlast closes the burst.
            over_d = 1'b1;
          end
        end
      end
      S_DROP: begin
        if (in_drop_done) begin
          cresp_d   = RESP_SLVERR;
          len_err_d = 1'b0;
          state_d   = S_RESP;
        end
      end
      S_RESP: begin
        if (in_cready) begin
          cresp_d   = RESP_OKAY;
          len_err_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      state_q   <= S_IDLE;
      cur_ok_q  <= 1'b0;
      cur_len_q <= '0;
      cnt_q     <= '0;
      over_q    <= 1'b0;
      cresp_q   <= RESP_OKAY;
      len_err_q <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_ok_q  <= cur_ok_d;
      cur_len_q <= cur_len_d;
      cnt_q     <= cnt_d;
      over_q    <= over_d;
      cresp_q   <= cresp_d;
      len_err_q <= len_err_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

  assign out_done    = done_q;
  assign out_drop    = drop_q;
  assign out_cvalid  = (state_q == S_RESP);
  assign out_cresp   = cresp_q;
  assign out_len_err = len_err_q;
  assign out_busy    = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_axi_wdata_sched.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_axi_wdata_sched : scoreboard bench for axi_wdata_sched             |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module tb_axi_wdata_sched;

  logic       clk = 1'b0;
  logic       reset_;
  logic       in_tvalid, out_tready, in_tok;
  logic [7:0] in_tlen;
  logic       out_done, out_drop, in_drop_done;
  logic       mon_wvalid, mon_wready, mon_wlast;
  logic       out_cvalid, in_cready;
  logic [1:0] out_cresp;
  logic       out_len_err;
  logic [3:0] out_pending;
  logic       out_busy;

  always #5 clk = ~clk;

  axi_wdata_sched #(.QDEPTH(8), .LEN_WIDTH(8)) dut (
    .clk          (clk),
    .reset_       (reset_),
    .in_tvalid    (in_tvalid),
    .out_tready   (out_tready),
    .in_tok       (in_tok),
    .in_tlen      (in_tlen),
    .out_done     (out_done),
    .out_drop     (out_drop),
    .in_drop_done (in_drop_done),
    .mon_wvalid   (mon_wvalid),
    .mon_wready   (mon_wready),
    .mon_wlast    (mon_wlast),
    .out_cvalid   (out_cvalid),
    .in_cready    (in_cready),
    .out_cresp    (out_cresp),
    .out_len_err  (out_len_err),
    .out_pending  (out_pending),
    .out_busy     (out_busy)
  );

  typedef struct {
    bit ok;
    int wlast_at;
    int drop_dly;
    bit gap;
  } plan_t;

  plan_t      plan_q[$];
  bit         exp_pulse_q[$];
  logic [2:0] exp_cmp_q[$];

  int n_pass  = 0;
  int n_total = 0;
  bit overlap_seen = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a pulse or a completion.
  always @(negedge clk) begin
    if (reset_ === 1'b1) begin
      if (out_done && out_drop) overlap_seen = 1'b1;
      if (out_done || out_drop) begin
        if (exp_pulse_q.size() == 0) check("pulse_unexpected", 32'(out_done | out_drop), 32'd0);
        else check("pulse_kind", 32'(out_done), 32'(exp_pulse_q.pop_front()));
      end
      if (out_cvalid && in_cready) begin
        if (exp_cmp_q.size() == 0) check("cmp_unexpected", 32'(out_cvalid), 32'd0);
        else check("completion", 32'({out_cresp, out_len_err}), 32'(exp_cmp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic push_v(input bit ok, input logic [7:0] len, input int wlast_at,
                        input int drop_dly, input bit gap,
                        input logic [1:0] exp_resp, input bit exp_lerr);
    plan_t p;
    int n;
    p.ok = ok; p.wlast_at = wlast_at; p.drop_dly = drop_dly; p.gap = gap;
    plan_q.push_back(p);
    exp_pulse_q.push_back(ok);
    exp_cmp_q.push_back({exp_resp, exp_lerr});
    in_tvalid = 1'b1; in_tok = ok; in_tlen = len;
    n = 0;
    while (!out_tready && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!out_tready) check("push_timeout", 32'(out_tready), 32'd1);
    @(posedge clk); #1;
    in_tvalid = 1'b0;
  endtask

  task automatic wait_pulse(output int lat);
    lat = 0;
    while (!(out_done || out_drop) && lat < 300) begin
      @(posedge clk); #1; lat++;
    end
    if (!(out_done || out_drop)) check("pulse_timeout", 32'(out_done | out_drop), 32'd1);
  endtask

  task automatic drive_w();
    plan_t p;
    if (plan_q.size() == 0) return;
    p = plan_q.pop_front();
    if (p.ok) begin
      for (int b = 1; b <= p.wlast_at; b++) begin
        if (p.gap) begin
          mon_wvalid = 1'b1; mon_wready = 1'b0; mon_wlast = 1'b1;
          @(posedge clk); #1;
        end
        mon_wvalid = 1'b1; mon_wready = 1'b1; mon_wlast = (b == p.wlast_at);
        @(posedge clk); #1;
      end
    end else begin
      // Beats presented while dropping must not end the burst.
      for (int i = 0; i < p.drop_dly; i++) begin
        mon_wvalid = 1'b1; mon_wready = 1'b1; mon_wlast = 1'b1;
        @(posedge clk); #1;
      end
      mon_wvalid = 1'b0; mon_wready = 1'b0; mon_wlast = 1'b0;
      in_drop_done = 1'b1;
      @(posedge clk); #1;
      in_drop_done = 1'b0;
    end
    mon_wvalid = 1'b0; mon_wready = 1'b0; mon_wlast = 1'b0;
  endtask

  task automatic wait_cvalid();
    int n = 0;
    while (!out_cvalid && n < 300) begin
      @(posedge clk); #1; n++;
    end
    if (!out_cvalid) check("cvalid_timeout", 32'(out_cvalid), 32'd1);
  endtask

  task automatic accept_resp();
    in_cready = 1'b1;
    @(posedge clk); #1;
    in_cready = 1'b0;
    check("busy_after_resp", 32'(out_busy), 32'd0);
  endtask

  task automatic serve(input int count);
    int lat;
    for (int i = 0; i < count; i++) begin
      wait_pulse(lat);
      drive_w();
      wait_cvalid();
      accept_resp();
    end
  endtask

  initial begin
    int  lat;
    logic [2:0] snap;
    bit  stable, quiet;
    reset_ = 1'b0; in_tvalid = 1'b0; in_tok = 1'b0; in_tlen = '0;
    in_drop_done = 1'b0; mon_wvalid = 1'b0; mon_wready = 1'b0; mon_wlast = 1'b0;
    in_cready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", 32'({out_tready, out_done, out_drop, out_cvalid, out_cresp,
                                out_len_err, out_pending, out_busy}), 32'h800);
    reset_ = 1'b1;
    @(posedge clk); #1;

    // 1: ok, 4 beats, wlast on 4th; pulse two cycles after the push edge
    push_v(1'b1, 8'd3, 4, 0, 1'b0, 2'b00, 1'b0);
    wait_pulse(lat);
    check("t1_latency", 32'(lat), 32'd2);
    drive_w(); wait_cvalid(); accept_resp();

    // 2: fault, drop_done 5 cycles after the drop pulse
    push_v(1'b0, 8'd7, 0, 5, 1'b0, 2'b10, 1'b0);
    serve(1);

    // 3: ok tlen=3, wlast on 2nd beat, stalled handshakes in between
    push_v(1'b1, 8'd3, 2, 0, 1'b1, 2'b10, 1'b1);
    serve(1);

    // overrun: tlen=1 but wlast on 4th beat
    push_v(1'b1, 8'd1, 4, 0, 1'b0, 2'b10, 1'b1);
    serve(1);

    // drop_done in the very cycle DROP is entered
    push_v(1'b0, 8'd0, 0, 0, 1'b0, 2'b10, 1'b0);
    serve(1);

    // 5 + 4: completion stalled 10 cycles while 8 verdicts fill the queue
    push_v(1'b1, 8'd2, 3, 0, 1'b0, 2'b00, 1'b0);
    wait_pulse(lat);
    drive_w();
    wait_cvalid();
    snap = {out_cresp, out_len_err};
    stable = 1'b1; quiet = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) push_v(1'b1, 8'd1, 2, 0, 1'b0, 2'b00, 1'b0);
      else            push_v(1'b0, 8'd3, 0, 2, 1'b0, 2'b10, 1'b0);
      if (!out_cvalid || {out_cresp, out_len_err} != snap) stable = 1'b0;
      if (out_done || out_drop) quiet = 1'b0;
    end
    check("t4_tready_full", 32'(out_tready), 32'd0);
    check("t4_pending_full", 32'(out_pending), 32'd8);
    fork
      push_v(1'b1, 8'd0, 1, 0, 1'b0, 2'b00, 1'b0);
      begin
        repeat (2) begin
          @(posedge clk); #1;
          if (!out_cvalid || {out_cresp, out_len_err} != snap) stable = 1'b0;
          if (out_done || out_drop) quiet = 1'b0;
        end
        check("t5_cmp_stable", 32'(stable), 32'd1);
        check("t5_no_pulse_in_stall", 32'(quiet), 32'd1);
        accept_resp();
        @(posedge clk); #1;
        check("t4_pending_after_pop", 32'(out_pending), 32'd7);
      end
    join
    serve(9);

    // 6: reset in the middle of SEND with two verdicts still queued
    for (int i = 0; i < 3; i++) push_v(1'b1, 8'd3, 4, 0, 1'b0, 2'b00, 1'b0);
    wait_pulse(lat);
    check("t6_pending", 32'(out_pending), 32'd2);
    void'(plan_q.pop_front());
    for (int b = 0; b < 2; b++) begin
      mon_wvalid = 1'b1; mon_wready = 1'b1; mon_wlast = 1'b0;
      @(posedge clk); #1;
    end
    reset_ = 1'b0; mon_wvalid = 1'b0; mon_wready = 1'b0;
    @(posedge clk); #1;
    check("t6_reset_outputs", 32'({out_tready, out_done, out_drop, out_cvalid, out_cresp,
                                   out_len_err, out_pending, out_busy}), 32'h800);
    reset_ = 1'b1;
    exp_pulse_q.delete(); exp_cmp_q.delete(); plan_q.delete();
    quiet = 1'b1;
    repeat (10) begin
      @(posedge clk); #1;
      if (out_cvalid || out_busy || out_done || out_drop) quiet = 1'b0;
    end
    check("t6_quiet_after_reset", 32'(quiet), 32'd1);

    // recovery: single-beat burst
    push_v(1'b1, 8'd0, 1, 0, 1'b0, 2'b00, 1'b0);
    serve(1);

    repeat (3) @(posedge clk);
    #1;
    check("sb_pulses_drained", 32'(exp_pulse_q.size()), 32'd0);
    check("sb_cmp_drained", 32'(exp_cmp_q.size()), 32'd0);
    check("no_pulse_overlap", 32'(overlap_seen), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
